// File: rtl/fps_meter_mc_if.sv
// rtl/fps_meter_mc_if.sv - vsync inputs, display select and latched frame-rate results
interface fps_meter_mc_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 10,
  parameter int DIGITS = 3
);
  logic [NUM_CH-1:0]          vs;
  logic [1:0]                 disp_sel;
  logic [NUM_CH*CNT_W-1:0]    fps;
  logic [NUM_CH*4*DIGITS-1:0] fps_bcd;
  logic [NUM_CH-1:0]          fps_sat;
  logic [NUM_CH-1:0]          no_signal;
  logic                       fps_valid;
  logic [DIGITS*7-1:0]        hex;

  modport master (
    output vs, disp_sel,
    input  fps, fps_bcd, fps_sat, no_signal, fps_valid, hex
  );

  modport slave (
    input  vs, disp_sel,
    output fps, fps_bcd, fps_sat, no_signal, fps_valid, hex
  );
endinterface

// File: rtl/fps_meter_mc.sv
// rtl/fps_meter_mc.sv - multi-channel vsync frame-rate meter with 7-segment readout
module fps_meter_mc #(
  parameter int NUM_CH      = 2,
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 10,
  parameter int DIGITS      = 3,
  parameter int BLANK_LZ    = 1
) (
  input  logic          clk50,
  input  logic          resetn,
  fps_meter_mc_if.slave bus
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int BW = 4 * DIGITS;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [BW-1:0]    BCD_MAX   = {DIGITS{4'h9}};
  localparam logic [BW-1:0]    BCD_ONE   = BW'(1);
  localparam logic [CNT_W-1:0] BIN_MAX   = '1;

  logic [NUM_CH-1:0] s1_q, s2_q, prev_q, edge_w;
  logic [GW-1:0]     gate_q;
  logic              we_w;

  logic [NUM_CH-1:0][CNT_W-1:0] bin_run_q, fps_q;
  logic [NUM_CH-1:0][BW-1:0]    bcd_run_q, fps_bcd_q;
  logic [NUM_CH-1:0]            sat_run_q, fps_sat_q, no_signal_q;
  logic                         fps_valid_q;

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  assign edge_w = s2_q & ~prev_q;
  assign we_w   = (gate_q == GATE_LAST);

  always_ff @(posedge clk50 or negedge resetn) begin
    if (!resetn) begin
      s1_q        <= '0;
      s2_q        <= '0;
      prev_q      <= '0;
      gate_q      <= '0;
      bin_run_q   <= '0;
      bcd_run_q   <= '0;
      sat_run_q   <= '0;
      fps_q       <= '0;
      fps_bcd_q   <= '0;
      fps_sat_q   <= '0;
      no_signal_q <= '1;
      fps_valid_q <= 1'b0;
    end else begin
      s1_q        <= bus.vs;
      s2_q        <= s1_q;
      prev_q      <= s2_q;
      gate_q      <= we_w ? '0 : gate_q + GW'(1);
      fps_valid_q <= we_w;
      for (int c = 0; c < NUM_CH; c++) begin
        if (we_w) begin
          fps_q[c]       <= bin_run_q[c];
          fps_bcd_q[c]   <= bcd_run_q[c];
          fps_sat_q[c]   <= sat_run_q[c];
          no_signal_q[c] <= (bin_run_q[c] == '0);
          // An edge landing on the window boundary seeds the next window.
          bin_run_q[c]   <= edge_w[c] ? CNT_W'(1) : '0;
          bcd_run_q[c]   <= edge_w[c] ? BCD_ONE : '0;
          sat_run_q[c]   <= 1'b0;
        end else if (edge_w[c]) begin
          if (bin_run_q[c] != BIN_MAX) bin_run_q[c] <= bin_run_q[c] + CNT_W'(1);
          if (bcd_run_q[c] != BCD_MAX) bcd_run_q[c] <= bcd_inc(bcd_run_q[c]);
          if (bin_run_q[c] == BIN_MAX || bcd_run_q[c] == BCD_MAX) sat_run_q[c] <= 1'b1;
        end
      end
    end
  end

  logic [BW-1:0]       sel_bcd;
  logic [3:0]          dig;
  logic                nz;
  logic [DIGITS*7-1:0] hex_w;

  always_comb begin
    sel_bcd = fps_bcd_q[0];
    for (int c = 1; c < NUM_CH; c++) begin
      if (bus.disp_sel == 2'(c)) sel_bcd = fps_bcd_q[c];
    end
    nz    = 1'b0;
    dig   = '0;
    hex_w = '0;
    // Scan from the most significant digit so blanking stops at the first nonzero.
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dig = sel_bcd[4*d +: 4];
      if (dig != 4'd0) nz = 1'b1;
      if (BLANK_LZ != 0 && !nz && d != 0) hex_w[7*d +: 7] = 7'h7F;
      else                                hex_w[7*d +: 7] = seg(dig);
    end
  end

  assign bus.fps       = fps_q;
  assign bus.fps_bcd   = fps_bcd_q;
  assign bus.fps_sat   = fps_sat_q;
  assign bus.no_signal = no_signal_q;
  assign bus.fps_valid = fps_valid_q;
  assign bus.hex       = hex_w;
endmodule

// File: tb/tb_fps_meter_mc.sv
// tb/tb_fps_meter_mc.sv - directed bench for fps_meter_mc in two configurations
module tb_fps_meter_mc;
  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  always #10 clk = ~clk;

  fps_meter_mc_if #(.NUM_CH(2), .CNT_W(10), .DIGITS(3)) ifa ();
  fps_meter_mc_if #(.NUM_CH(1), .CNT_W(10), .DIGITS(2)) ifb ();

  fps_meter_mc #(.NUM_CH(2), .GATE_CYCLES(100), .CNT_W(10), .DIGITS(3), .BLANK_LZ(1)) dut_a (
    .clk50 (clk),
    .resetn(resetn),
    .bus   (ifa)
  );

  fps_meter_mc #(.NUM_CH(1), .GATE_CYCLES(300), .CNT_W(10), .DIGITS(2), .BLANK_LZ(0)) dut_b (
    .clk50 (clk),
    .resetn(resetn),
    .bus   (ifb)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic pulse_a(input logic [1:0] m);
    ifa.vs = m;
    @(negedge clk);
    ifa.vs = 2'b00;
    @(negedge clk);
  endtask

  task automatic pulse_b();
    ifb.vs = 1'b1;
    @(negedge clk);
    ifb.vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_ph(input logic [1:0] m, input int ph);
    @(negedge clk);
    #(ph);
    ifa.vs = m;
    #20;
    ifa.vs = 2'b00;
  endtask

  task automatic wait_valid_a();
    int n;
    n = 0;
    while (ifa.fps_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("valid_a_seen", 64'(n < 400), 64'd1);
  endtask

  task automatic wait_valid_b();
    int n;
    n = 0;
    while (ifb.fps_valid !== 1'b1 && n < 700) begin
      @(negedge clk);
      n++;
    end
    check("valid_b_seen", 64'(n < 700), 64'd1);
  endtask

  initial begin
    resetn       = 1'b0;
    ifa.vs       = 2'b00;
    ifa.disp_sel = 2'd0;
    ifb.vs       = 1'b0;
    ifb.disp_sel = 2'd0;
    repeat (3) @(negedge clk);

    check("rst_fps",       ifa.fps, 0);
    check("rst_bcd",       ifa.fps_bcd, 0);
    check("rst_nosig",     ifa.no_signal, 2'b11);
    check("rst_valid",     ifa.fps_valid, 0);
    check("rst_hex_a",     ifa.hex, {7'h7F, 7'h7F, 7'h40});
    check("rst_hex_b",     ifb.hex, {7'h40, 7'h40});
    resetn = 1'b1;

    // window 1: ch0 7 pulses, ch1 23 pulses
    for (int i = 0; i < 23; i++) pulse_a({1'b1, i < 7});
    wait_valid_a();
    check("w1_fps",   ifa.fps, {10'd23, 10'd7});
    check("w1_bcd",   ifa.fps_bcd, {12'h023, 12'h007});
    check("w1_nosig", ifa.no_signal, 2'b00);
    check("w1_sat",   ifa.fps_sat, 2'b00);
    ifa.disp_sel = 2'd1;
    #1;
    check("w1_hex_sel1", ifa.hex, {7'h7F, 7'h24, 7'h30});
    @(negedge clk);
    check("w1_valid_pulse", ifa.fps_valid, 0);

    // window 2: ch1 idle, ch0 3 pulses
    for (int i = 0; i < 3; i++) pulse_a(2'b01);
    wait_valid_a();
    check("w2_fps",   ifa.fps, {10'd0, 10'd3});
    check("w2_nosig", ifa.no_signal, 2'b10);
    check("w2_hex_sel1", ifa.hex, {7'h7F, 7'h7F, 7'h40});
    ifa.disp_sel = 2'd0;
    #1;
    check("w2_hex_sel0", ifa.hex, {7'h7F, 7'h7F, 7'h30});
    ifa.disp_sel = 2'd3;
    #1;
    check("w2_hex_sel3", ifa.hex, {7'h7F, 7'h7F, 7'h30});

    // window 3: 4 pulses then one whose edge lands exactly on the window end
    for (int i = 0; i < 4; i++) pulse_a(2'b01);
    repeat (89) @(negedge clk);
    ifa.vs = 2'b01;
    @(negedge clk);
    ifa.vs = 2'b00;
    wait_valid_a();
    check("w3_fps_excl", ifa.fps[9:0], 10'd4);

    // window 4: 2 phase-shifted 1-cycle pulses on top of the carried edge
    pulse_ph(2'b01, 3);
    pulse_ph(2'b01, 13);
    wait_valid_a();
    check("w4_fps_carry", ifa.fps[9:0], 10'd3);
    check("w3w4_total",   64'(ifa.fps[9:0]) + 64'd4, 64'd7);
    check("w4_hex_sel3",  ifa.hex, {7'h7F, 7'h7F, 7'h30});

    // reset mid-window after 40 edges
    for (int i = 0; i < 40; i++) pulse_a(2'b01);
    resetn = 1'b0;
    #1;
    check("mid_rst_fps",   ifa.fps, 0);
    check("mid_rst_bcd",   ifa.fps_bcd, 0);
    check("mid_rst_sat",   ifa.fps_sat, 0);
    check("mid_rst_nosig", ifa.no_signal, 2'b11);
    check("mid_rst_hex",   ifa.hex, {7'h7F, 7'h7F, 7'h40});
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) pulse_a({i < 2, 1'b1});
    wait_valid_a();
    check("post_rst_fps",   ifa.fps, {10'd2, 10'd5});
    check("post_rst_nosig", ifa.no_signal, 2'b00);

    // config B: idle window, then saturation at 99, then recovery
    wait_valid_b();
    check("b_idle_fps",   ifb.fps, 0);
    check("b_idle_nosig", ifb.no_signal, 1'b1);
    check("b_idle_hex",   ifb.hex, {7'h40, 7'h40});
    for (int i = 0; i < 120; i++) pulse_b();
    wait_valid_b();
    check("b_sat_fps", ifb.fps, 10'd120);
    check("b_sat_bcd", ifb.fps_bcd, 8'h99);
    check("b_sat_flag", ifb.fps_sat, 1'b1);
    check("b_sat_hex", ifb.hex, {7'h10, 7'h10});
    for (int i = 0; i < 5; i++) pulse_b();
    wait_valid_b();
    check("b_rec_fps", ifb.fps, 10'd5);
    check("b_rec_bcd", ifb.fps_bcd, 8'h05);
    check("b_rec_sat", ifb.fps_sat, 1'b0);
    check("b_rec_hex", ifb.hex, {7'h40, 7'h12});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
